// File: rtl/r22sdf_frame_ctrl_if.sv
// Signal bundle between the R2²SDF frame sequencer, its sample source/sink and the FFT core.
// master = sequencer side, slave = environment side (source, sink and core).
interface r22sdf_frame_ctrl_if #(
  parameter int DATA_RES = 16,
  parameter int LOG2_LEN = 6
);
  // Valid/ready: a sample moves only on a cycle with s_valid & s_ready. The source holds
  // s_din/s_last stable while s_valid is high. s_ready never depends on s_valid.
  // The m_* side has no backpressure: m_valid marks a live bin.
  logic                fft_rdy;
  logic                s_valid;
  logic                s_ready;
  logic                s_last;
  logic [DATA_RES-1:0] s_din_r;
  logic [DATA_RES-1:0] s_din_i;
  logic                fft_en;
  logic [DATA_RES-1:0] fft_din_r;
  logic [DATA_RES-1:0] fft_din_i;
  logic [DATA_RES-1:0] fft_dout_r;
  logic [DATA_RES-1:0] fft_dout_i;
  logic                m_valid;
  logic                m_sop;
  logic                m_eop;
  logic [LOG2_LEN-1:0] m_bin;
  logic [DATA_RES-1:0] m_dout_r;
  logic [DATA_RES-1:0] m_dout_i;
  logic                busy;
  logic                frame_err;
  // Debug view of the sequencer state: 0 WAIT_RDY, 1 IDLE, 2 RUN, 3 FLUSH.
  logic [1:0]          dbg_state;

  modport master (
    input  fft_rdy, s_valid, s_last, s_din_r, s_din_i, fft_dout_r, fft_dout_i,
    output s_ready, fft_en, fft_din_r, fft_din_i, m_valid, m_sop, m_eop, m_bin,
           m_dout_r, m_dout_i, busy, frame_err, dbg_state
  );

  modport slave (
    output fft_rdy, s_valid, s_last, s_din_r, s_din_i, fft_dout_r, fft_dout_i,
    input  s_ready, fft_en, fft_din_r, fft_din_i, m_valid, m_sop, m_eop, m_bin,
           m_dout_r, m_dout_i, busy, frame_err, dbg_state
  );
endinterface

// File: rtl/r22sdf_frame_ctrl.sv
// Frame sequencer for the 64-point R2²SDF FFT core: gates the core enable, zero-flushes
// after the last frame and tags each core output with valid/sop/eop and its natural-order bin.
module r22sdf_frame_ctrl #(
  parameter int DATA_RES = 16,
  parameter int FFT_LEN  = 64,
  parameter int LOG2_LEN = 6,
  parameter int PIPE_LAT = 79
) (
  input logic                 sys_clk,
  input logic                 sys_rst,
  r22sdf_frame_ctrl_if.master bus
);
  localparam int FILL_W  = $clog2(PIPE_LAT + 1);
  localparam int OUTST_W = $clog2(PIPE_LAT + FFT_LEN + 1);

  localparam logic [1:0] ST_WAIT_RDY = 2'd0;
  localparam logic [1:0] ST_IDLE     = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;
  localparam logic [1:0] ST_FLUSH    = 2'd3;

  localparam logic [LOG2_LEN-1:0] LAST_IDX = LOG2_LEN'(FFT_LEN - 1);
  localparam logic [FILL_W-1:0]   FILL_MAX = FILL_W'(PIPE_LAT);

  logic [1:0]          state_q,     state_d;
  logic [LOG2_LEN-1:0] in_cnt_q,    in_cnt_d;
  logic [LOG2_LEN-1:0] out_cnt_q,   out_cnt_d;
  logic [FILL_W-1:0]   fill_q,      fill_d;
  logic [OUTST_W-1:0]  outst_q,     outst_d;
  logic                frame_err_q, frame_err_d;

  logic                in_phase;
  logic                accept;
  logic                en;
  logic                mval;
  logic [LOG2_LEN-1:0] bin_rev;

  always_comb begin
    // Losing fft_rdy after start-up freezes everything: no enable, no accept, no counting.
    in_phase = (state_q == ST_IDLE) || (state_q == ST_RUN);
    accept   = bus.fft_rdy & in_phase & bus.s_valid;
    en       = bus.fft_rdy & ((in_phase & bus.s_valid) | (state_q == ST_FLUSH));
    // fill tells us when the core's first real sample reaches its output.
    mval     = en & (fill_q >= FILL_MAX) & (outst_q != '0);

    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    fill_d      = fill_q;
    outst_d     = outst_q + OUTST_W'(accept) - OUTST_W'(mval);
    frame_err_d = frame_err_q;

    if (accept) in_cnt_d = in_cnt_q + LOG2_LEN'(1);
    if (mval) out_cnt_d = out_cnt_q + LOG2_LEN'(1);
    if (en && (fill_q < FILL_MAX)) fill_d = fill_q + FILL_W'(1);
    if (accept && (bus.s_last != (in_cnt_q == LAST_IDX))) frame_err_d = 1'b1;

    case (state_q)
      ST_WAIT_RDY: if (bus.fft_rdy) state_d = ST_IDLE;
      ST_IDLE:     if (accept) state_d = ST_RUN;
      ST_RUN: begin
        // Only a gap exactly on a frame boundary starts the flush; mid-frame gaps just stall.
        if (bus.fft_rdy && (in_cnt_q == '0) && !bus.s_valid && (outst_q != '0))
          state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (mval && (outst_q == OUTST_W'(1))) begin
          state_d = ST_IDLE;
          fill_d  = '0;
        end
      end
      default: state_d = ST_WAIT_RDY;
    endcase
  end

  always_comb begin
    bin_rev = '0;
    for (int k = 0; k < LOG2_LEN; k++) bin_rev[k] = out_cnt_q[LOG2_LEN-1-k];
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_WAIT_RDY;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      fill_q      <= '0;
      outst_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      fill_q      <= fill_d;
      outst_q     <= outst_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.s_ready   = bus.fft_rdy & in_phase;
  assign bus.fft_en    = en;
  assign bus.fft_din_r = (state_q == ST_FLUSH) ? '0 : bus.s_din_r;
  assign bus.fft_din_i = (state_q == ST_FLUSH) ? '0 : bus.s_din_i;
  assign bus.m_valid   = mval;
  assign bus.m_sop     = mval & (out_cnt_q == '0);
  assign bus.m_eop     = mval & (out_cnt_q == LAST_IDX);
  assign bus.m_bin     = bin_rev;
  assign bus.m_dout_r  = bus.fft_dout_r;
  assign bus.m_dout_i  = bus.fft_dout_i;
  assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign bus.frame_err = frame_err_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_r22sdf_frame_ctrl.sv
// Bench for r22sdf_frame_ctrl: the core is modelled as a pure enable-gated delay line, so every
// accepted sample must reappear on m_dout in order, tagged by its position in the output stream.
`timescale 1ns/1ps
module tb_r22sdf_frame_ctrl;
  localparam int DATA_RES = 16;
  localparam int FFT_LEN  = 64;
  localparam int LOG2_LEN = 6;
  localparam int PIPE_LAT = 79;
  localparam logic [1:0] S_WAIT  = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd3;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic rdy_base = 1'b0;
  logic rdy_rand_en = 1'b0;
  logic rdy_noise;

  always #5 sys_clk = ~sys_clk;

  r22sdf_frame_ctrl_if #(.DATA_RES(DATA_RES), .LOG2_LEN(LOG2_LEN)) bus ();

  r22sdf_frame_ctrl #(
    .DATA_RES(DATA_RES), .FFT_LEN(FFT_LEN), .LOG2_LEN(LOG2_LEN), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus(bus)
  );

  assign bus.fft_rdy = rdy_base & rdy_noise;

  initial begin
    rdy_noise = 1'b1;
    forever begin
      @(posedge sys_clk); #1;
      rdy_noise = rdy_rand_en ? ($urandom_range(0, 7) != 0) : 1'b1;
    end
  end

  // Core stand-in: output at enable cycle k+PIPE_LAT equals input at enable cycle k.
  logic [DATA_RES-1:0] pipe_r [PIPE_LAT];
  logic [DATA_RES-1:0] pipe_i [PIPE_LAT];
  assign bus.fft_dout_r = pipe_r[PIPE_LAT-1];
  assign bus.fft_dout_i = pipe_i[PIPE_LAT-1];

  initial begin
    for (int k = 0; k < PIPE_LAT; k++) begin
      pipe_r[k] = 16'hbad0 ^ 16'(k);
      pipe_i[k] = 16'h5a5a;
    end
    forever begin
      @(posedge sys_clk);
      if (bus.fft_en) begin
        pipe_r[0] <= bus.fft_din_r;
        pipe_i[0] <= bus.fft_din_i;
        for (int k = 1; k < PIPE_LAT; k++) begin
          pipe_r[k] <= pipe_r[k-1];
          pipe_i[k] <= pipe_i[k-1];
        end
      end
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [LOG2_LEN-1:0] bitrev(input int v);
    logic [LOG2_LEN-1:0] r;
    for (int k = 0; k < LOG2_LEN; k++) r[k] = v[LOG2_LEN-1-k];
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [2*DATA_RES-1:0] exp_q[$];
  int out_idx  = 0;
  int acc_idx  = 0;
  int acc_cnt  = 0;
  int en_idx   = 0;
  int cyc      = 0;
  int mv_cnt   = 0;
  int sop_cnt  = 0;
  int flush_cnt = 0;
  int last_mv_cyc = 0;
  logic err_exp = 1'b0;
  int mv_en_q[$];
  logic [LOG2_LEN-1:0] bins_q[$];

  always @(negedge sys_clk) begin
    logic [2*DATA_RES-1:0] exp_s;
    cyc++;
    if (bus.fft_en) en_idx++;
    if (sys_rst) begin
      exp_q.delete();
      out_idx = 0;
      acc_idx = 0;
      err_exp = 1'b0;
    end else begin
      check("frame_err", 64'(bus.frame_err), 64'(err_exp));
      if (bus.dbg_state == S_FLUSH) flush_cnt++;
      if (bus.m_valid) begin
        mv_cnt++;
        last_mv_cyc = cyc;
        mv_en_q.push_back(en_idx);
        bins_q.push_back(bus.m_bin);
        if (bus.m_sop) sop_cnt++;
        check("m_valid_without_en", 64'(bus.fft_en), 64'(1));
        if (exp_q.size() == 0) begin
          check("m_valid_spurious", 64'(bus.m_valid), 64'(0));
        end else begin
          exp_s = exp_q.pop_front();
          check("m_dout", 64'({bus.m_dout_r, bus.m_dout_i}), 64'(exp_s));
        end
        check("m_sop", 64'(bus.m_sop), 64'((out_idx % FFT_LEN) == 0));
        check("m_eop", 64'(bus.m_eop), 64'((out_idx % FFT_LEN) == FFT_LEN - 1));
        check("m_bin", 64'(bus.m_bin), 64'(bitrev(out_idx % FFT_LEN)));
        out_idx++;
      end else begin
        check("sop_eop_idle", 64'({bus.m_sop, bus.m_eop}), 64'(0));
      end
      if (bus.s_valid && bus.s_ready) begin
        check("fft_en_on_accept", 64'(bus.fft_en), 64'(1));
        check("fft_din", 64'({bus.fft_din_r, bus.fft_din_i}), 64'({bus.s_din_r, bus.s_din_i}));
        exp_q.push_back({bus.s_din_r, bus.s_din_i});
        if (bus.s_last != ((acc_idx % FFT_LEN) == FFT_LEN - 1)) err_exp = 1'b1;
        acc_idx++;
        acc_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick_mon();
    @(negedge sys_clk); #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
  endtask

  task automatic send(input logic [DATA_RES-1:0] r, input logic [DATA_RES-1:0] i, input logic last);
    int guard;
    guard = 0;
    bus.s_valid = 1'b1;
    bus.s_din_r = r;
    bus.s_din_i = i;
    bus.s_last  = last;
    @(negedge sys_clk);
    while (!bus.s_ready && guard < 500) begin
      @(negedge sys_clk);
      guard++;
    end
    if (guard >= 500) check("send_timeout", 64'(bus.s_ready), 64'(1));
    @(posedge sys_clk); #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input bit chk);
    bus.s_valid = 1'b0;
    repeat (n) begin
      @(negedge sys_clk);
      if (chk) begin
        check("stall_fft_en", 64'(bus.fft_en), 64'(0));
        check("stall_m_valid", 64'(bus.m_valid), 64'(0));
      end
      @(posedge sys_clk); #1;
    end
  endtask

  // mode 0: impulse (1000,0) then zeros; mode 1: random samples.
  task automatic send_frame(input int mode, input int stall_at, input int last_at, input bit rand_gaps);
    for (int s = 0; s < FFT_LEN; s++) begin
      logic [DATA_RES-1:0] r;
      logic [DATA_RES-1:0] i;
      if (s == stall_at) idle_cycles(10, 1'b1);
      if (rand_gaps && $urandom_range(0, 7) == 0) idle_cycles($urandom_range(1, 5), 1'b0);
      if (mode == 0) begin
        r = (s == 0) ? 16'd1000 : 16'd0;
        i = 16'd0;
      end else begin
        r = 16'($urandom);
        i = 16'($urandom);
      end
      send(r, i, s == last_at);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
      tick_mon();
      n++;
    end
    check("drain_timeout", 64'(n < budget), 64'(1));
    @(posedge sys_clk); #1;
  endtask

  // ---------------- vectors ----------------
  typedef struct packed {
    logic                rdy;
    logic                vld;
    logic                last;
    logic [DATA_RES-1:0] din;
    logic                e_ready;
    logic                e_en;
    logic                e_busy;
    logic                e_err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int base_mv, base_sop, base_flush, base_en, base_bin, n;
    int first_bins[5];
    first_bins = '{0, 32, 16, 48, 8};
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_din_r = '0;
    bus.s_din_i = '0;

    // Walk from WAIT_RDY through IDLE into RUN with stalls, an fft_rdy drop and a bad s_last.
    vecs[0] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 16'h3333, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 16'h4444, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 16'h5555, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 16'h6666, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 16'h7777, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 16'h8888, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b1, 1'b1};

    rdy_base = 1'b0;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      rdy_base    = vecs[k].rdy;
      bus.s_valid = vecs[k].vld;
      bus.s_last  = vecs[k].last;
      bus.s_din_r = vecs[k].din;
      bus.s_din_i = ~vecs[k].din;
      @(negedge sys_clk);
      check($sformatf("vec%0d_s_ready", k), 64'(bus.s_ready), 64'(vecs[k].e_ready));
      check($sformatf("vec%0d_fft_en", k), 64'(bus.fft_en), 64'(vecs[k].e_en));
      check($sformatf("vec%0d_busy", k), 64'(bus.busy), 64'(vecs[k].e_busy));
      check($sformatf("vec%0d_frame_err", k), 64'(bus.frame_err), 64'(vecs[k].e_err));
      @(posedge sys_clk); #1;
    end

    // Startup: reset state, then 20 cycles without fft_rdy.
    rdy_base = 1'b0;
    do_reset();
    @(negedge sys_clk);
    check("rst_state", 64'(bus.dbg_state), 64'(S_WAIT));
    check("rst_outputs", 64'({bus.s_ready, bus.fft_en, bus.m_valid, bus.m_sop, bus.m_eop,
                              bus.busy, bus.frame_err}), 64'(0));
    check("rst_m_bin", 64'(bus.m_bin), 64'(0));
    bus.s_valid = 1'b1;
    repeat (20) begin
      @(negedge sys_clk);
      check("wait_rdy_s_ready", 64'(bus.s_ready), 64'(0));
      check("wait_rdy_fft_en", 64'(bus.fft_en), 64'(0));
    end
    @(posedge sys_clk); #1;
    bus.s_valid = 1'b0;
    rdy_base = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("startup_s_ready", 64'(bus.s_ready), 64'(1));
    @(posedge sys_clk); #1;

    // Single impulse frame followed by a flush.
    base_mv  = mv_cnt;
    base_bin = bins_q.size();
    send_frame(0, -1, FFT_LEN - 1, 1'b0);
    tick_mon();
    tick_mon();
    check("impulse_flush_entered", 64'(bus.dbg_state), 64'(S_FLUSH));
    n = 0;
    while (bus.dbg_state == S_FLUSH && n < 400) begin
      check("flush_fft_en", 64'(bus.fft_en), 64'(1));
      check("flush_s_ready", 64'(bus.s_ready), 64'(0));
      tick_mon();
      n++;
    end
    check("impulse_idle", 64'(bus.dbg_state), 64'(S_IDLE));
    check("impulse_busy", 64'(bus.busy), 64'(0));
    check("impulse_fft_en_off", 64'(bus.fft_en), 64'(0));
    check("impulse_mv_count", 64'(mv_cnt - base_mv), 64'(FFT_LEN));
    check("impulse_flush_end", 64'(cyc - last_mv_cyc), 64'(1));
    if (bins_q.size() >= base_bin + FFT_LEN) begin
      for (int k = 0; k < 5; k++)
        check("impulse_bin_seq", 64'(bins_q[base_bin + k]), 64'(first_bins[k]));
      check("impulse_last_bin", 64'(bins_q[base_bin + FFT_LEN - 1]), 64'(FFT_LEN - 1));
    end
    @(posedge sys_clk); #1;

    // Three back-to-back frames with continuous s_valid.
    base_mv    = mv_cnt;
    base_sop   = sop_cnt;
    base_flush = flush_cnt;
    base_en    = mv_en_q.size();
    for (int f = 0; f < 3; f++) send_frame(1, -1, FFT_LEN - 1, 1'b0);
    check("b2b_no_early_flush", 64'(flush_cnt - base_flush), 64'(0));
    drain(1000);
    check("b2b_mv_count", 64'(mv_cnt - base_mv), 64'(3 * FFT_LEN));
    check("b2b_sop_count", 64'(sop_cnt - base_sop), 64'(3));
    if (mv_en_q.size() >= base_en + 3 * FFT_LEN)
      check("b2b_no_gaps", 64'(mv_en_q[base_en + 3 * FFT_LEN - 1] - mv_en_q[base_en]),
            64'(3 * FFT_LEN - 1));

    // Mid-frame stall while the previous frame is streaming out.
    base_mv = mv_cnt;
    send_frame(1, -1, FFT_LEN - 1, 1'b0);
    send_frame(1, 20, FFT_LEN - 1, 1'b0);
    drain(1000);
    check("stall_mv_count", 64'(mv_cnt - base_mv), 64'(2 * FFT_LEN));

    // Framing error: s_last on sample 40.
    do_reset();
    for (int s = 0; s < FFT_LEN; s++) begin
      send(16'($urandom), 16'($urandom), s == 40);
      if (s == 39) check("ferr_before", 64'(bus.frame_err), 64'(0));
      if (s == 40) check("ferr_after", 64'(bus.frame_err), 64'(1));
    end
    drain(1000);
    check("ferr_sticky", 64'(bus.frame_err), 64'(1));

    // Reset in the middle of a flush.
    base_mv = mv_cnt;
    send_frame(1, -1, FFT_LEN - 1, 1'b0);
    n = 0;
    while (!(bus.dbg_state == S_FLUSH && (mv_cnt - base_mv) >= 10) && n < 600) begin
      tick_mon();
      n++;
    end
    check("midflush_reached", 64'(n < 600), 64'(1));
    @(posedge sys_clk); #1;
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("midflush_state", 64'(bus.dbg_state), 64'(S_WAIT));
    check("midflush_outputs", 64'({bus.s_ready, bus.fft_en, bus.m_valid, bus.m_sop, bus.m_eop,
                                   bus.busy, bus.frame_err}), 64'(0));
    check("midflush_m_bin", 64'(bus.m_bin), 64'(0));
    @(posedge sys_clk); #1;
    base_mv = mv_cnt;
    idle_cycles(200, 1'b0);
    check("midflush_no_mv", 64'(mv_cnt - base_mv), 64'(0));

    // Randomized frames with gaps, fft_rdy drops and occasional misplaced s_last.
    do_reset();
    base_mv = mv_cnt;
    n = acc_cnt;
    rdy_rand_en = 1'b1;
    for (int f = 0; f < 5; f++) begin
      send_frame(1, -1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : FFT_LEN - 1,
                 1'b1);
      idle_cycles($urandom_range(0, 3), 1'b0);
    end
    rdy_rand_en = 1'b0;
    drain(3000);
    check("rand_all_out", 64'(mv_cnt - base_mv), 64'(acc_cnt - n));
    check("rand_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/r22sdf_frame_ctrl.md
Name: r22sdf_frame_ctrl

Overview:
- Frame sequencer in front of the 64-point R2²SDF FFT core.
- Accepts a valid/ready sample stream and drives the core's enable and data inputs.
- Counts core enable cycles to recover output timing and zero-flushes the pipeline after the last frame.
- Tags each core output with valid, start/end-of-frame and the natural-order bin index, since the core emits bins in bit-reversed order.

Parameters:
- DATA_RES, 16, sample width per I/Q component.
- FFT_LEN, 64, points per frame; power of 4.
- LOG2_LEN, 6, log2(FFT_LEN).
- PIPE_LAT, 79, core latency in enable cycles (input sample to corresponding output); must match the instantiated core configuration.

Ports:
- sys_clk  in  1  clock.
- sys_rst  in  1  synchronous active-high reset.
- fft_rdy  in  1  core ready (CORDIC twiddle init done).
- s_valid  in  1  input sample valid.
- s_ready  out  1  input sample accepted when s_valid & s_ready.
- s_last  in  1  marks the final sample of an input frame.
- s_din_r  in  DATA_RES  input real part.
- s_din_i  in  DATA_RES  input imaginary part.
- fft_en  out  1  core enable (core sys_en).
- fft_din_r  out  DATA_RES  core input real part.
- fft_din_i  out  DATA_RES  core input imaginary part.
- fft_dout_r  in  DATA_RES  core output real part.
- fft_dout_i  in  DATA_RES  core output imaginary part.
- m_valid  out  1  output sample valid.
- m_sop  out  1  first bin of an output frame.
- m_eop  out  1  last bin of an output frame.
- m_bin  out  LOG2_LEN  natural-order bin index of the current output.
- m_dout_r  out  DATA_RES  output real part.
- m_dout_i  out  DATA_RES  output imaginary part.
- busy  out  1  state is RUN or FLUSH.
- frame_err  out  1  sticky s_last misalignment flag.

Behaviour:
- Clock and reset: one clock, sys_clk. sys_rst is synchronous and active-high.
- Reset (also mid-operation, which drops in-flight data):
  - state=WAIT_RDY.
  - All counters 0.
  - s_ready, fft_en, m_valid, m_sop, m_eop, busy, frame_err all 0.
  - m_bin=0.
- Counters:
  - in_cnt (LOG2_LEN bits): +1 on each accept, wraps FFT_LEN-1→0.
  - fill (saturates at PIPE_LAT): +1 on each fft_en cycle.
  - outst (outstanding real samples): +1 on accept, −1 on m_valid; +1 and −1 in the same cycle leave it unchanged.
  - out_cnt (LOG2_LEN bits): +1 on m_valid, wraps.
- States:
  - WAIT_RDY: s_ready=0, fft_en=0. Go to IDLE when fft_rdy=1.
  - IDLE: s_ready=1. On accept, fft_en=1 with fft_din = s_din, and go to RUN.
  - RUN: s_ready=1; fft_en = s_valid. A mid-frame stall freezes the core pipeline and emits no m_valid. When in_cnt==0 (frame boundary), s_valid=0 and outst>0, go to FLUSH.
  - FLUSH: s_ready=0, fft_en=1, fft_din=0. Stay until outst reaches 0 (the m_valid cycle that decrements outst to 0). Then go to IDLE and clear fill to 0.
- fft_din equals s_din in RUN/IDLE and 0 in FLUSH. fft_en is combinational from state, s_valid and fft_rdy.
- Output tagging:
  - m_valid = fft_en & (fill ≥ PIPE_LAT) & (outst > 0).
  - m_dout = fft_dout in the same cycle (passthrough; zero added latency).
  - m_sop = m_valid & (out_cnt==0); m_eop = m_valid & (out_cnt==FFT_LEN-1).
  - m_bin = bit-reverse(out_cnt) over LOG2_LEN bits.
  - Flush zeros never produce m_valid once outst=0.
- fft_rdy=0 in any state other than WAIT_RDY: fft_en=0, s_ready=0, state and counters hold.
- s_last checks:
  - s_last accepted with in_cnt≠FFT_LEN-1 sets frame_err (sticky until reset).
  - An accept with in_cnt==FFT_LEN-1 and s_last=0 also sets frame_err.
  - Framing itself is governed by in_cnt only.
- busy = state is RUN or FLUSH.

Test Plan:
- Startup: hold fft_rdy=0 for 20 cycles after reset → s_ready=0, fft_en=0. Raise fft_rdy → s_ready=1 on the next cycle.
- Single impulse frame: one frame with sample0=(1000,0), rest 0, s_last on sample 63, then idle.
  - FLUSH entered and fft_en held high exactly until 64 m_valid pulses have been emitted.
  - m_sop on the first pulse, m_eop on the 64th.
  - m_bin sequence 0,32,16,48,8,…,63.
  - All outputs ≈(1000,0) at core scaling; then IDLE with busy=0.
- Back-to-back frames: 3 frames, s_valid continuous.
  - No FLUSH until after frame 3.
  - 192 m_valid with no gaps once fill saturates.
  - m_sop every 64 outputs.
- Mid-frame stall: drop s_valid for 10 cycles at sample 20 → fft_en=0 and m_valid=0 for those cycles; out_cnt and m_bin sequence continue unbroken afterward.
- Framing error: assert s_last at sample 40 → frame_err=1 from the next cycle and stays 1; the stream continues to be processed.
- Reset mid-FLUSH: sys_rst for 1 cycle → all outputs 0 and state WAIT_RDY on the following cycle, with no m_valid afterward.
